// File: rtl/vdp_pattern_if.sv
// VDP pixel-stream bundle between the pattern source and the scaler.
//   enable        half-rate pixel-clock enable
//   vdp_hcounter  line position, 0..H_TOTAL-1
//   vdp_vcounter  frame line, 0..V_TOTAL-1
//   vdp_r/g/b     6-bit colour, 0 outside the active window
//   active        colour belongs to the active window
//   frame_start   1-clk pulse after the counters wrap to h=v=0
interface vdp_pattern_if;
  logic        enable;
  logic [10:0] vdp_hcounter;
  logic [10:0] vdp_vcounter;
  logic [5:0]  vdp_r;
  logic [5:0]  vdp_g;
  logic [5:0]  vdp_b;
  logic        active;
  logic        frame_start;

  modport master (output enable, vdp_hcounter, vdp_vcounter, vdp_r, vdp_g, vdp_b,
                  active, frame_start);
  modport slave  (input  enable, vdp_hcounter, vdp_vcounter, vdp_r, vdp_g, vdp_b,
                  active, frame_start);
endinterface

// File: rtl/vdp_pattern_source.sv
// VDP-side test pattern generator feeding the scaler input.
// Produces a half-rate enable, line/frame counters and a 6-bit RGB pattern
// (solid, colour bars, grid, stripe-7). Used for bring-up in place of the VDP.
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   run          1: generate, 0: freeze counters and colour
//   pattern_sel  0 solid, 1 bars, 2 grid, 3 stripe-7 (taken at frame wrap)
//   fg_color     {r,g,b} for the solid pattern, used live
//   vdp          pixel stream (master side of vdp_pattern_if)
module vdp_pattern_source #(
  parameter int H_TOTAL     = 1368,
  parameter int V_TOTAL     = 524,
  parameter int H_ACT_START = 256,
  parameter int H_ACT_PIX   = 256,
  parameter int V_ACT_START = 40,
  parameter int V_ACT_LINES = 424
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         run,
  input  logic [1:0]   pattern_sel,
  input  logic [17:0]  fg_color,
  vdp_pattern_if.master vdp
);

  typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_GRID, PAT_STRIPE} pat_e;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_S    = 11'(H_ACT_START);
  localparam logic [10:0] H_E    = 11'(H_ACT_START + 4 * H_ACT_PIX);
  localparam logic [10:0] V_S    = 11'(V_ACT_START);
  localparam logic [10:0] V_E    = 11'(V_ACT_START + V_ACT_LINES);

  logic        en_q, act_q, fs_q;
  logic [10:0] h_q, v_q;
  pat_e        pat_q;
  logic [2:0]  m7_q;
  logic [5:0]  r_q, g_q, b_q;

  logic        h_last, v_last, in_act, stripe_hi;
  logic [2:0]  bar, m7_cur;
  logic [3:0]  px_lo, row_lo;
  logic [1:0]  sub;
  logic [5:0]  r_n, g_n, b_n;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign in_act = (h_q >= H_S) && (h_q < H_E) && (v_q >= V_S) && (v_q < V_E);

  // Offsets are 11-bit differences; only the bits each pattern needs are kept.
  assign bar    = 3'((h_q - H_S) >> 7);
  assign px_lo  = 4'((h_q - H_S) >> 2);
  assign sub    = 2'(h_q - H_S);
  assign row_lo = 4'((v_q - V_S) >> 1);

  // Stripe count restarts on the first active count of every line.
  assign m7_cur    = (h_q == H_S) ? 3'd0 : m7_q;
  assign stripe_hi = (m7_cur < 3'd3);

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (in_act) begin
      unique case (pat_q)
        PAT_SOLID: {r_n, g_n, b_n} = fg_color;
        PAT_BARS: begin
          r_n = {6{bar[1]}};
          g_n = {6{bar[2]}};
          b_n = {6{bar[0]}};
        end
        PAT_GRID: begin
          if (px_lo == 4'd0 || row_lo == 4'd0) {r_n, g_n, b_n} = {3{6'h3F}};
          else                                 {r_n, g_n, b_n} = {3{6'h01}};
        end
        default: begin
          if (stripe_hi) {r_n, g_n, b_n} = {3{6'h3F}};
          else           {r_n, g_n, b_n} = {3{6'h01}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q  <= 1'b0;
      fs_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      pat_q <= PAT_SOLID;
      m7_q  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      act_q <= 1'b0;
    end else begin
      en_q <= run & ~en_q;
      // Cleared on every clk so the pulse lasts one clk, not one enable period.
      fs_q <= en_q & h_last & v_last;
      if (en_q) begin
        h_q <= h_last ? 11'd0 : h_q + 11'd1;
        if (h_last) v_q <= v_last ? 11'd0 : v_q + 11'd1;
        // Pattern changes only at the frame boundary so a frame never tears.
        if (h_last && v_last) pat_q <= pat_e'(pattern_sel);
        // Colour reflects the pre-increment position: one enabled step of lag.
        r_q   <= r_n;
        g_q   <= g_n;
        b_q   <= b_n;
        act_q <= in_act;
        if (in_act) m7_q <= (sub != 2'd3) ? m7_cur : (m7_cur == 3'd6) ? 3'd0 : m7_cur + 3'd1;
      end
    end
  end

  assign vdp.enable       = en_q;
  assign vdp.vdp_hcounter = h_q;
  assign vdp.vdp_vcounter = v_q;
  assign vdp.vdp_r        = r_q;
  assign vdp.vdp_g        = g_q;
  assign vdp.vdp_b        = b_q;
  assign vdp.active       = act_q;
  assign vdp.frame_start  = fs_q;

endmodule

// File: tb/tb_vdp_pattern_source.sv
module tb_vdp_pattern_source;
  localparam int H = 1032, V = 6, HS = 4, PIX = 256, VS = 1, VL = 4;
  localparam logic [17:0] FG  = {6'h2A, 6'h15, 6'h33};
  localparam logic [17:0] WHT = 18'h3FFFF;
  localparam logic [17:0] DIM = 18'h01041;
  // bars row: target h, colour, active
  localparam int          BH [8] = '{3, 4, 132, 260, 644, 900, 1027, 1028};
  localparam logic [17:0] BC [8] = '{18'h0, 18'h0, 18'h0003F, 18'h3F000, 18'h00FFF, WHT, WHT, 18'h0};
  localparam logic        BA [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // grid row 1 (v=3): target h, colour
  localparam int          GH [5] = '{4, 8, 68, 72, 75};
  localparam logic [17:0] GC [5] = '{WHT, DIM, WHT, DIM, DIM};
  // stripe: per-pixel colour for pixels 0..8
  localparam logic [17:0] SC [9] = '{WHT, WHT, WHT, DIM, DIM, DIM, DIM, WHT, WHT};

  logic        clk = 1'b0;
  logic        reset_n, run;
  logic [1:0]  pattern_sel;
  logic [17:0] fg_color;
  logic [17:0] rgb;
  int          n_checks = 0, n_pass = 0;

  vdp_pattern_if vif();

  vdp_pattern_source #(
    .H_TOTAL(H), .V_TOTAL(V), .H_ACT_START(HS), .H_ACT_PIX(PIX),
    .V_ACT_START(VS), .V_ACT_LINES(VL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pattern_sel(pattern_sel),
    .fg_color(fg_color), .vdp(vif.master)
  );

  always #5 clk = ~clk;
  assign rgb = {vif.vdp_r, vif.vdp_g, vif.vdp_b};

  // Advance to the first negedge where the counters show (th,tv); the colour
  // outputs then describe position th-1.
  task automatic wait_hv(input int th, input int tv);
    int cyc = 0;
    while (!(vif.vdp_hcounter == 11'(th) && vif.vdp_vcounter == 11'(tv)) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40000) begin
      n_checks++;
      $display("FAIL wait_hv: h=%0d v=%0d not reached within 40000 clks", th, tv);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; run = 1'b0; pattern_sel = 2'd1; fg_color = FG;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({vif.enable, vif.vdp_hcounter, vif.vdp_vcounter, rgb, vif.active, vif.frame_start} !== '0)
      $display("FAIL reset_outputs: en=%b h=%0d v=%0d rgb=%h act=%b fs=%b, want all 0",
               vif.enable, vif.vdp_hcounter, vif.vdp_vcounter, rgb, vif.active, vif.frame_start);
    else n_pass++;
    run = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({vif.enable, vif.vdp_hcounter} !== '0)
      $display("FAIL reset_beats_run: en=%b h=%0d, want 0/0", vif.enable, vif.vdp_hcounter);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  // Whole first frame plus wrap, solid pattern (pattern_sel=1 must not apply yet).
  task automatic test_counters;
    int err_line = 0, err_frame = 0, err_solid = 0, pulses = 0, pulse_ok = 0;
    int n, q, eh, ev, qh, qv;
    logic een, efs, eact;
    logic [17:0] erg;
    for (int k = 1; k <= 2 * H * V + 4; k++) begin
      @(negedge clk);
      n   = k / 2;
      eh  = n % H;
      ev  = (n / H) % V;
      een = (k % 2) == 1;
      efs = (k % 2 == 0) && (n % (H * V) == 0);
      if (vif.enable !== een || vif.vdp_hcounter !== 11'(eh) || vif.vdp_vcounter !== 11'(ev)) begin
        if (k <= 2 * H + 2) err_line++;
        else                err_frame++;
      end
      if (vif.frame_start !== efs) err_frame++;
      if (vif.frame_start === 1'b1) begin
        pulses++;
        if (vif.vdp_hcounter == 11'd0 && vif.vdp_vcounter == 11'd0) pulse_ok++;
      end
      eact = 1'b0;
      if (n >= 1) begin
        q  = n - 1;
        qh = q % H;
        qv = (q / H) % V;
        eact = (qh >= HS) && (qh < HS + 4 * PIX) && (qv >= VS) && (qv < VS + VL);
      end
      erg = eact ? FG : 18'h0;
      if (vif.active !== eact || rgb !== erg) err_solid++;
    end
    n_checks++;
    if (err_line !== 0) $display("FAIL line_count: %0d bad cycles, want 0", err_line);
    else n_pass++;
    n_checks++;
    if (err_frame !== 0) $display("FAIL frame_count: %0d bad cycles, want 0", err_frame);
    else n_pass++;
    n_checks++;
    if (err_solid !== 0) $display("FAIL solid_frame: %0d bad cycles, want 0", err_solid);
    else n_pass++;
    n_checks++;
    if (pulses !== 1 || pulse_ok !== 1)
      $display("FAIL frame_start_pulse: pulses=%0d at_hv0=%0d, want 1/1", pulses, pulse_ok);
    else n_pass++;
  endtask

  // Second frame: bars, then pattern_sel=2 mid-frame must not tear.
  task automatic test_bars;
    wait_hv(HS + 1, 0);
    n_checks++;
    if (rgb !== 18'h0 || vif.active !== 1'b0)
      $display("FAIL bars_v_before: rgb=%h act=%b, want 0/0", rgb, vif.active);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      wait_hv(BH[i] + 1, VS);
      n_checks++;
      if (rgb !== BC[i] || vif.active !== BA[i])
        $display("FAIL bars_h%0d: rgb=%h act=%b, want %h/%b", BH[i], rgb, vif.active, BC[i], BA[i]);
      else n_pass++;
    end
    pattern_sel = 2'd2;
    wait_hv(HS + 129, VS + VL - 1);
    n_checks++;
    if (rgb !== 18'h0003F || vif.active !== 1'b1)
      $display("FAIL bars_hold_after_sel: rgb=%h act=%b, want 0003f/1", rgb, vif.active);
    else n_pass++;
    wait_hv(HS + 129, VS + VL);
    n_checks++;
    if (rgb !== 18'h0 || vif.active !== 1'b0)
      $display("FAIL bars_v_after: rgb=%h act=%b, want 0/0", rgb, vif.active);
    else n_pass++;
  endtask

  task automatic test_grid;
    wait_hv(HS + 21, VS);
    n_checks++;
    if (rgb !== WHT) $display("FAIL grid_row0: rgb=%h, want %h", rgb, WHT);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      wait_hv(GH[i] + 1, VS + 2);
      n_checks++;
      if (rgb !== GC[i] || vif.active !== 1'b1)
        $display("FAIL grid_h%0d: rgb=%h act=%b, want %h/1", GH[i], rgb, vif.active, GC[i]);
      else n_pass++;
    end
    pattern_sel = 2'd3;
  endtask

  task automatic test_stripe;
    int bad = 0;
    for (int p = 0; p < 9; p++) begin
      for (int off = 0; off < 4; off += 3) begin
        wait_hv(HS + 4 * p + off + 1, VS);
        if (rgb !== SC[p]) bad++;
      end
    end
    n_checks++;
    if (bad !== 0) $display("FAIL stripe_seq: %0d bad samples, want 0", bad);
    else n_pass++;
    wait_hv(HS + 1024, VS);
    n_checks++;
    if (rgb !== DIM) $display("FAIL stripe_last_px: rgb=%h, want %h", rgb, DIM);
    else n_pass++;
    wait_hv(HS + 1, VS + 1);
    n_checks++;
    if (rgb !== WHT) $display("FAIL stripe_restart_px0: rgb=%h, want %h", rgb, WHT);
    else n_pass++;
    wait_hv(HS + 13, VS + 1);
    n_checks++;
    if (rgb !== DIM) $display("FAIL stripe_restart_px3: rgb=%h, want %h", rgb, DIM);
    else n_pass++;
    wait_hv(HS + 29, VS + 1);
    n_checks++;
    if (rgb !== WHT) $display("FAIL stripe_restart_px7: rgb=%h, want %h", rgb, WHT);
    else n_pass++;
  endtask

  task automatic test_freeze_reset;
    int bad = 0;
    wait_hv(700, VS + 1);
    n_checks++;
    if (vif.enable !== 1'b0 || rgb !== DIM || vif.active !== 1'b1)
      $display("FAIL freeze_entry: en=%b rgb=%h act=%b, want 0/%h/1", vif.enable, rgb, vif.active, DIM);
    else n_pass++;
    run = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (vif.enable !== 1'b0 || vif.vdp_hcounter !== 11'd700 || rgb !== DIM || vif.active !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL freeze_hold: %0d bad cycles, want 0", bad);
    else n_pass++;
    run = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vif.enable !== 1'b1 || vif.vdp_hcounter !== 11'd700)
      $display("FAIL resume_1: en=%b h=%0d, want 1/700", vif.enable, vif.vdp_hcounter);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (vif.enable !== 1'b0 || vif.vdp_hcounter !== 11'd701 || rgb !== DIM)
      $display("FAIL resume_2: en=%b h=%0d rgb=%h, want 0/701/%h", vif.enable, vif.vdp_hcounter, rgb, DIM);
    else n_pass++;
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({vif.enable, vif.vdp_hcounter, vif.vdp_vcounter, rgb, vif.active, vif.frame_start} !== '0)
      $display("FAIL midline_reset: en=%b h=%0d v=%0d rgb=%h act=%b fs=%b, want all 0",
               vif.enable, vif.vdp_hcounter, vif.vdp_vcounter, rgb, vif.active, vif.frame_start);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (vif.vdp_hcounter !== 11'd1 || vif.vdp_vcounter !== 11'd0 || vif.enable !== 1'b0)
      $display("FAIL restart: h=%0d v=%0d en=%b, want 1/0/0", vif.vdp_hcounter, vif.vdp_vcounter, vif.enable);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_counters;
    test_bars;
    test_grid;
    test_stripe;
    test_freeze_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
